vc_mem_arb: RTL
===============

// Module: vc_mem_arb
// PURPOSE
//  Shares the single byte-wide external memory port between the I-cache line-fill path and the
//  D-cache fill/write path of the vc CPU.
//  Arbitrates the two requesters round-robin and sequences each 16-bit transaction as:
//    address bytes -> optional read wait -> two data bytes -> one-cycle ack.
//  Sits between the caches/MMU and the uio pad bus.
// PARAMETERS
//  PA       24  physical address width; must be a multiple of 8; NAB = PA/8 address bytes
//  RD_WAIT   2  turnaround/wait cycles between the last address byte and the first read data byte (>=1)
// PORTS
//  clk       in   1   clock
//  rst_n     in   1   asynchronous active-low reset
//  i_req     in   1   I-cache read request; held high until i_ack
//  i_addr    in   PA  I-cache byte address (bit 0 ignored, halfword access)
//  i_ack     out  1   one-cycle pulse: i_rdata valid, transaction done
//  i_rdata   out  16  read data to I-cache
//  d_req     in   1   D-cache request; held high until d_ack
//  d_wr      in   1   1 = write, 0 = read; stable while d_req high
//  d_addr    in   PA  D-cache byte address (bit 0 ignored)
//  d_wdata   in   16  write data
//  d_ack     out  1   one-cycle pulse: done (d_rdata valid on reads)
//  d_rdata   out  16  read data to D-cache
//  mem_cs    out  1   high for every ADDR/WAIT/DATA cycle of a transaction
//  mem_wr    out  1   transaction is a write; valid while mem_cs high
//  mem_out   out  8   address/write byte to pads
//  mem_oe    out  1   1 = drive mem_out on pads
//  mem_in    in   8   read byte from pads
//  busy      out  1   state != IDLE
//  gnt_d     out  1   current/last owner: 1 = D-cache, 0 = I-cache
// BEHAVIOUR
//  - Reset (async, rst_n low): state=IDLE; all outputs 0; rdata regs 0; last-owner = I-cache.
//  - FSM states: IDLE, ADDR, WAIT, DATA, ACK.
//  - IDLE:
//      no req            -> stay.
//      exactly one req   -> grant it.
//      both req          -> grant the one NOT last served, so the first tie after reset goes to D.
//      Grant latches owner, address, write flag and wdata; next state ADDR.
//  - ADDR: NAB cycles; mem_out = address bytes MSB first; mem_oe=1; mem_cs=1.
//      After the last byte: read -> WAIT, write -> DATA.
//  - WAIT (reads only): RD_WAIT cycles; mem_oe=0; mem_cs=1.
//  - DATA: 2 cycles, low byte first.
//      Write: mem_out = wdata[7:0] then wdata[15:8]; mem_oe=1.
//      Read: mem_oe=0; mem_in sampled at the end of each DATA cycle into rdata[7:0] then rdata[15:8].
//  - ACK: 1 cycle; owner's ack=1; mem_cs=0; mem_oe=0; rdata held stable from ACK until the next
//    read for that owner completes. ACK -> IDLE.
//  - Latency: ack is asserted in the cycle N after the IDLE grant cycle.
//      Read:  N = 1+NAB+RD_WAIT+2 (8 at defaults).
//      Write: N = 1+NAB+2 (6 at defaults).
//  - Back-to-back: at least one IDLE cycle between transactions; a still-high req is re-evaluated there.
//  - Requester must drop req in the cycle after its ack, else it is re-granted.
//  - req dropped mid-transaction: transaction still completes and ack still pulses. No abort.
//  - Latched fields ignore input changes after the grant.
//  - Never both acks in one cycle; mem_oe never 1 in WAIT, read DATA or ACK.
//  - rst_n low mid-transaction: immediate return to reset state; no ack; mem_cs drops asynchronously.
// TESTING
//  1. i_req, i_addr=0x123456; mem_in=0x34 then 0x12 in DATA.
//     -> mem_out 12,34,56 with mem_oe=1; 2 WAIT cycles; i_ack at cycle 8; i_rdata=0x1234.
//  2. d_req, d_wr=1, d_addr=0x00ABCE, d_wdata=0xBEEF.
//     -> mem_out 00,AB,CE,EF,BE; mem_wr=1; d_ack at cycle 6; i_ack never asserted.
//  3. i_req and d_req together, held through 3 transactions.
//     -> owner order D, I, D; gnt_d toggles; one IDLE cycle between each.
//  4. Read in progress, rst_n pulsed low in WAIT.
//     -> outputs 0 immediately; no ack; the next tie after reset goes to D.
//  5. i_req dropped during ADDR.
//     -> transaction completes and i_ack still pulses at cycle 8; FSM then IDLE.
//  6. RD_WAIT=1, PA=16.
//     -> read ack at cycle 6, write ack at cycle 5; two address bytes only.

Source files
------------

// File: rtl/vc_mem_arb.sv
// Round-robin arbiter that shares the byte-wide external memory port between the I-cache
// fill path and the D-cache fill/write path. Each transaction is address bytes, an optional
// read wait, two data bytes and a one-cycle ack.
module vc_mem_arb #(
    parameter int unsigned PA      = 24,
    parameter int unsigned RD_WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [PA-1:0] i_addr,
    output logic          i_ack,
    output logic [15:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [PA-1:0] d_addr,
    input  logic [15:0]   d_wdata,
    output logic          d_ack,
    output logic [15:0]   d_rdata,
    output logic          mem_cs,
    output logic          mem_wr,
    output logic [7:0]    mem_out,
    output logic          mem_oe,
    input  logic [7:0]    mem_in,
    output logic          busy,
    output logic          gnt_d
);
    localparam int unsigned NAB    = PA / 8;
    localparam int unsigned CntMax = (NAB > RD_WAIT) ? NAB : RD_WAIT;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [CW-1:0] AddrLast = CW'(NAB - 1);
    localparam logic [CW-1:0] WaitLast = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] DataLast = CW'(1);
    localparam logic [PA-1:0] AddrMask = ~PA'(1);

    typedef enum logic [2:0] {StIdle, StAddr, StWait, StData, StAck} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [PA-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [7:0]    rlo_q, rlo_d;
    logic [15:0]   i_rdata_q, i_rdata_d;
    logic [15:0]   d_rdata_q, d_rdata_d;
    logic          take_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rlo_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rlo_q     <= rlo_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rlo_d     = rlo_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        // On a tie the requester that was not served last wins.
        take_d    = d_req && (!i_req || !owner_q);
        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    owner_d = take_d;
                    wr_d    = take_d && d_wr;
                    addr_d  = (take_d ? d_addr : i_addr) & AddrMask;
                    wdata_d = d_wdata;
                    cnt_d   = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                addr_d = addr_q << 8;
                if (cnt_q == AddrLast) begin
                    cnt_d   = '0;
                    state_d = wr_q ? StData : StWait;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWait: begin
                if (cnt_q == WaitLast) begin
                    cnt_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StData: begin
                // Low byte is staged so the owner's rdata only changes when the read completes.
                if (!wr_q) begin
                    if (cnt_q == '0) begin
                        rlo_d = mem_in;
                    end else if (owner_q) begin
                        d_rdata_d = {mem_in, rlo_q};
                    end else begin
                        i_rdata_d = {mem_in, rlo_q};
                    end
                end
                if (cnt_q == DataLast) begin
                    cnt_d   = '0;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_cs  = 1'b0;
        mem_oe  = 1'b0;
        mem_out = '0;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        unique case (state_q)
            StAddr: begin
                mem_cs  = 1'b1;
                mem_oe  = 1'b1;
                mem_out = addr_q[PA-1 -: 8];
            end
            StWait: mem_cs = 1'b1;
            StData: begin
                mem_cs = 1'b1;
                if (wr_q) begin
                    mem_oe  = 1'b1;
                    mem_out = (cnt_q == '0) ? wdata_q[7:0] : wdata_q[15:8];
                end
            end
            StAck: begin
                i_ack = !owner_q;
                d_ack = owner_q;
            end
            default: ;
        endcase
    end

    assign mem_wr  = mem_cs && wr_q;
    assign busy    = (state_q != StIdle);
    assign gnt_d   = owner_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
